imem_stim_driver: RTL
=====================

Name: imem_stim_driver

Overview:
- Synthesizable instruction-memory stimulus source for the sodor_formal harness; generalises the fixed two-word alternating imem data feed.
- Serves instruction words from a parametrised, run-time-loadable program table. Two modes:
  - free-running, cycle-indexed;
  - request/response, address-indexed, with configurable response latency.
- Keeps the harness cycle counter and raises done after a bounded run.

Parameters:
- DEPTH, 2, program table entries; power of 2, range 2..64.
- WORD, 32, instruction word width.
- LATENCY, 1, address-mode response latency in cycles; range 1..4.
- MAX_CYCLES, 100, run length in cycles before done.
- INIT_W0, 32'h04002283, reset value of entry 0.
- INIT_W1, 32'h00200313, reset value of entry 1.
- NOP_WORD, 32'h00000013, reset value of entries 2..DEPTH-1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = cycle-indexed, 1 = address-indexed.
- cfg_wr_en  input  1  program table write strobe.
- cfg_wr_idx  input  $clog2(DEPTH)  table write index.
- cfg_wr_data  input  WORD  table write data.
- req_valid  input  1  core imem request valid (mode 1).
- req_addr  input  32  core imem byte address (mode 1).
- req_ready  output  1  request accepted this cycle.
- resp_valid  output  1  resp_data valid this cycle.
- resp_data  output  WORD  instruction word to core (io_imem_resp_bits_data).
- cycle_cnt  output  32  cycles elapsed since reset deasserted.
- done  output  1  run complete.

Behaviour:
- Clock/reset: one clock clk; reset is synchronous and active-high.
- Reset values:
  - cycle_cnt=0, done=0, req_ready=0, resp_valid=0, resp_data=0.
  - Pipeline valids cleared.
  - Table restored to INIT_W0, INIT_W1, then NOP_WORD.
  - Reset asserted mid-run aborts in-flight responses; nothing is emitted afterwards.
- cycle_cnt:
  - +1 per cycle while !done.
  - done registers to 1 on the cycle cnt reaches MAX_CYCLES. Sticky until reset.
  - cycle_cnt holds at MAX_CYCLES.
- Mode 0 (cycle-indexed):
  - resp_valid = !reset && !done.
  - resp_data = table[cycle_cnt mod DEPTH]; combinational from registered state, so zero latency.
  - req_ready=0; req_valid is ignored.
  - With default parameters the stream is 04002283, 00200313, 04002283, ... starting at cycle_cnt=0.
- Mode 1 (address-indexed):
  - req_ready = !done.
  - Accept when req_valid && req_ready; index = req_addr[2+:$clog2(DEPTH)], so the address wraps modulo DEPTH words.
  - The word is captured from the table in the accept cycle.
  - It is presented exactly LATENCY cycles later with resp_valid=1, through a LATENCY-stage shift pipeline.
  - Back-to-back accepts give back-to-back responses, in order, with no backpressure on the response side.
  - When resp_valid=0, resp_data=0.
- Done: requests are refused, but responses already in flight still drain.
- Mode change:
  - takes effect the next cycle;
  - clears all pipeline valids (in-flight mode-1 responses are dropped);
  - cycle_cnt is unaffected.
- Table writes:
  - take effect on the next cycle;
  - a same-cycle read of the same index returns the old word;
  - writes are allowed while done.
- Simultaneous reset and cfg_wr_en: reset wins.

Optional Feature:
- Macro: IMEM_STIM_STALL_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) steps every cycle.
  - stall = (lfsr[1:0]==2'b00).
  - Mode 1: req_ready is forced 0 on stall cycles.
  - Mode 0: resp_valid is forced 0 on stall cycles, and cycle_cnt still advances (words for stalled indices are skipped).
- When undefined: no LFSR is built, and there are no stalls.

Test Plan:
- Defaults, mode=0, reset for 2 cycles, then release → resp_data 04002283 at cnt 0, 00200313 at cnt 1, alternating; resp_valid=1 throughout.
- Run to completion → done=1 at cycle_cnt=100; resp_valid=0 from that cycle on; cycle_cnt holds at 100.
- DEPTH=4, mode=0, write idx2=0x00100093 and idx3=0x00000073 → stream 04002283, 00200313, 00100093, 00000073, repeating.
- mode=1, LATENCY=3, req_addr 0x0, 0x4, 0x8 on consecutive cycles → responses on cycles +3, +4, +5 with words 04002283, 00200313, 04002283 (0x8 wraps to idx0).
- mode=1, two requests in flight, then mode toggled → no resp_valid for either request.
- mode=1, one request in flight, then reset asserted → no resp_valid for that request; table returns to init values.
- IMEM_STIM_STALL_EN defined, mode=1, req_valid held high for 64 cycles → req_ready low exactly on cycles where the reference LFSR model gives lfsr[1:0]==0; response count equals accept count.

Source files
------------

// File: rtl/imem_stim_driver.sv
// imem_stim_driver: instruction-memory stimulus source for the sodor_formal
// harness. Serves words from a run-time-loadable program table, either
// cycle-indexed (mode 0, zero latency) or address-indexed with a fixed
// LATENCY-cycle response pipeline (mode 1). Keeps the harness cycle counter
// and raises a sticky done after MAX_CYCLES.
// Optional build macro: IMEM_STIM_STALL_EN adds LFSR-driven stall cycles.
module imem_stim_driver #(
  parameter int              DEPTH      = 2,
  parameter int              WORD       = 32,
  parameter int              LATENCY    = 1,
  parameter int              MAX_CYCLES = 100,
  parameter logic [WORD-1:0] INIT_W0    = 32'h04002283,
  parameter logic [WORD-1:0] INIT_W1    = 32'h00200313,
  parameter logic [WORD-1:0] NOP_WORD   = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic                     cfg_wr_en,
  input  logic [$clog2(DEPTH)-1:0] cfg_wr_idx,
  input  logic [WORD-1:0]          cfg_wr_data,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  output logic                     req_ready,
  output logic                     resp_valid,
  output logic [WORD-1:0]          resp_data,
  output logic [31:0]              cycle_cnt,
  output logic                     done
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [31:0] MAX_CNT = 32'(MAX_CYCLES);

  // Program table and per-entry reset contents
  logic [WORD-1:0] table_q [DEPTH];

  function automatic logic [WORD-1:0] init_word(input int idx);
    if (idx == 0)      return INIT_W0;
    else if (idx == 1) return INIT_W1;
    else               return NOP_WORD;
  endfunction

  // Run bookkeeping
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic        done_q, done_d;
  logic        mode_q;

  // Address-mode response pipeline; stage LATENCY-1 drives the output
  logic [LATENCY-1:0] pipe_v_q;
  logic [WORD-1:0]    pipe_d_q [LATENCY];

  logic             stall;
  logic             accept;
  logic             flush;
  logic             mode0_valid;
  logic             mode1_valid;
  logic [IDX_W-1:0] cnt_idx;
  logic [IDX_W-1:0] req_idx;
  logic             unused_addr_bits;

`ifdef IMEM_STIM_STALL_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0 every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Only the word-index bits of the byte address select a table entry
  assign req_idx          = req_addr[2 +: IDX_W];
  assign unused_addr_bits = ^{req_addr[31:2+IDX_W], req_addr[1:0]};
  assign cnt_idx          = cycle_cnt_q[IDX_W-1:0];

  // A mode change discards everything in flight, including this cycle's accept
  assign flush = (mode != mode_q);

  assign req_ready   = !reset && mode_q && !done_q && !stall;
  assign accept      = req_valid && req_ready;
  assign mode0_valid = !reset && !mode_q && !done_q && !stall;
  // In-flight responses drain even after done
  assign mode1_valid = !reset && mode_q && pipe_v_q[LATENCY-1];

  assign resp_valid = mode0_valid || mode1_valid;
  assign resp_data  = mode0_valid ? table_q[cnt_idx] :
                      mode1_valid ? pipe_d_q[LATENCY-1] : '0;
  assign cycle_cnt  = cycle_cnt_q;
  assign done       = done_q;

  // Counter advances until it lands on MAX_CYCLES, where done goes high together
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    done_d      = done_q;
    if (!done_q) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
      done_d      = (cycle_cnt_d == MAX_CNT);
    end
  end

  // Counter, done flag and the effective mode (adopted one cycle after the input)
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      done_q      <= 1'b0;
      mode_q      <= mode;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      done_q      <= done_d;
      mode_q      <= mode;
    end
  end

  // Program table: reset restores init contents; writes land at the edge so
  // a same-cycle read still sees the old word
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= init_word(i);
      end
    end else if (cfg_wr_en) begin
      table_q[cfg_wr_idx] <= cfg_wr_data;
    end
  end

  // Response pipeline valids: shift by one stage per cycle, cleared on flush
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_v_q <= '0;
    end else begin
      pipe_v_q[0] <= accept && !flush;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1] && !flush;
      end
    end
  end

  // Response pipeline data: word captured from the table in the accept cycle
  always_ff @(posedge clk) begin
    pipe_d_q[0] <= table_q[req_idx];
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d_q[i] <= pipe_d_q[i-1];
    end
  end

endmodule
